// File: rtl/in_block_assembler_if.sv
// Byte-in / block-out handshake bundle for the AES input block assembler.
// slave: the assembler itself; master: the host/AES-side driver of the bus.
// Carries the byte lane, 128-bit block lane, clear strobe and buffer fill count.
interface in_block_assembler_if;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic         clear;
   logic [127:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic [3:0]   byte_cnt;

   modport slave (
      input  in_data, in_valid, clear, out_ready,
      output in_ready, out_data, out_valid, byte_cnt
   );

   modport master (
      output in_data, in_valid, clear, out_ready,
      input  in_ready, out_data, out_valid, byte_cnt
   );
endinterface

// File: rtl/in_block_assembler.sv
// Packs 16 host bytes (byte 0 in LSBs) into a 128-bit AES block; optional
// double buffering via IN_ASM_DOUBLE_BUF_EN. Latency: block valid 1 cycle after 16th byte.
// Backpressure: in_ready drops (from registered state only) while no block slot is free.
module in_block_assembler (
   input  logic                 clk,
   input  logic                 rst,
   in_block_assembler_if.slave  bus
);

`ifdef IN_ASM_DOUBLE_BUF_EN
   // Assembly buffer holds a full block so it can park one behind out_data.
   localparam int ASM_W = 128;
   typedef enum logic [1:0] {ST_FILL, ST_FILL_HOLD, ST_STALL} state_t;
`else
   // Last byte goes straight into out_data, so only 15 bytes are buffered.
   localparam int ASM_W = 120;
   typedef enum logic {ST_FILL, ST_HOLD} state_t;
`endif

   state_t             state_q, state_d;
   logic [ASM_W-1:0]   asm_q, asm_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [127:0]       out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;

   logic               accept;
   logic               last;
   logic               xfer;
   logic               clear_en;
   logic [127:0]       blk_new;

`ifdef IN_ASM_DOUBLE_BUF_EN
   assign bus.in_ready = !rst && (state_q != ST_STALL);
   // A completed block parked in STALL is not a partial block; clear leaves it alone.
   assign clear_en     = bus.clear && (state_q != ST_STALL);
`else
   assign bus.in_ready = !rst && (state_q == ST_FILL);
   assign clear_en     = bus.clear;
`endif

   // clear wins over a byte offered in the same cycle
   assign accept  = bus.in_valid && bus.in_ready && !bus.clear;
   assign last    = (cnt_q == 4'd15);
   assign xfer    = out_valid_q && bus.out_ready;
   assign blk_new = {bus.in_data, asm_q[119:0]};

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.byte_cnt  = cnt_q;

   // Next-state: byte placement, block hand-off and output handshake
   always_comb begin
      state_d     = state_q;
      asm_d       = asm_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (clear_en) begin
         cnt_d = 4'd0;
         asm_d = '0;
      end else if (accept && !last) begin
         asm_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
         cnt_d = cnt_q + 4'd1;
      end

`ifdef IN_ASM_DOUBLE_BUF_EN
      case (state_q)
         ST_FILL: begin
            if (accept && last) begin
               out_data_d  = blk_new;
               out_valid_d = 1'b1;
               cnt_d       = 4'd0;
               asm_d       = '0;
               state_d     = ST_FILL_HOLD;
            end
         end
         ST_FILL_HOLD: begin
            if (accept && last) begin
               cnt_d = 4'd0;
               if (xfer) begin
                  // old block leaves as the new one completes: no bubble
                  out_data_d = blk_new;
                  asm_d      = '0;
               end else begin
                  asm_d[127:120] = bus.in_data;
                  state_d        = ST_STALL;
               end
            end else if (xfer) begin
               out_valid_d = 1'b0;
               state_d     = ST_FILL;
            end
         end
         ST_STALL: begin
            if (xfer) begin
               out_data_d = asm_q;
               asm_d      = '0;
               state_d    = ST_FILL_HOLD;
            end
         end
         default: state_d = ST_FILL;
      endcase
`else
      if (xfer) begin
         out_valid_d = 1'b0;
         state_d     = ST_FILL;
      end
      if (accept && last) begin
         out_data_d  = blk_new;
         out_valid_d = 1'b1;
         cnt_d       = 4'd0;
         asm_d       = '0;
         state_d     = ST_HOLD;
      end
`endif
   end

   // State registers with synchronous reset discarding any data in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_FILL;
         asm_q       <= '0;
         cnt_q       <= 4'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         asm_q       <= asm_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_in_block_assembler.sv
// Randomized scoreboard bench for in_block_assembler.
// Reference model: a byte list packed into blocks plus a count of blocks in flight.
// Monitor checks handshake outputs every cycle and pops blocks on each transfer.
module tb_in_block_assembler;

`ifdef IN_ASM_DOUBLE_BUF_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic clk;
   logic rst;

   in_block_assembler_if bus ();

   in_block_assembler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [127:0] part;
   int           part_cnt  = 0;
   int           pending   = 0;
   int           made      = 0;
   int           flushed   = 0;
   int           delivered = 0;
   logic [127:0] exp_q[$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // one clock: drive at posedge+1, sample handshake at negedge, update model at posedge
   task automatic step(input logic v, input logic [7:0] d, input logic c,
                       input logic ordy, input logic r, output logic acc);
      logic xf;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.clear     = c;
      bus.out_ready = ordy;
      rst           = r;
      @(negedge clk);
      acc = v && bus.in_ready && !c && !r;
      xf  = bus.out_valid && ordy && !r;
      @(posedge clk);
      if (r) begin
         part_cnt = 0;
         part     = '0;
         pending  = 0;
         flushed += exp_q.size();
         exp_q.delete();
      end else begin
         if (c) begin
            part_cnt = 0;
            part     = '0;
         end else if (acc) begin
            part[8*part_cnt +: 8] = d;
            part_cnt++;
            if (part_cnt == 16) begin
               exp_q.push_back(part);
               made++;
               pending++;
               part_cnt = 0;
               part     = '0;
            end
         end
         if (xf) pending--;
      end
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic ordy);
      logic a;
      int   n;
      n = 0;
      a = 1'b0;
      while (!a && n < 200) begin
         step(1'b1, d, 1'b0, ordy, 1'b0, a);
         n++;
      end
      if (!a) chk("send_timeout", 128'd0, 128'd1);
   endtask

   task automatic idle(input logic ordy, input int n);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, ordy, 1'b0, a);
   endtask

   // monitor: per-cycle handshake checks and scoreboard pop on transfer
   initial begin
      logic         p_vld, p_rdy, p_rst;
      logic [127:0] p_dat;
      logic [127:0] e;
      p_vld = 1'b0;
      p_rdy = 1'b0;
      p_rst = 1'b1;
      p_dat = '0;
      forever begin
         @(negedge clk);
         chk("in_ready",  {127'd0, bus.in_ready},  {127'd0, (!rst && pending < CAP)});
         chk("out_valid", {127'd0, bus.out_valid}, {127'd0, (pending > 0)});
         chk("byte_cnt",  {124'd0, bus.byte_cnt},  {124'd0, part_cnt[3:0]});
         if (p_rst) begin
            chk("rst_out_data", bus.out_data, 128'd0);
         end else if (p_vld && !p_rdy) begin
            chk("hold_valid", {127'd0, bus.out_valid}, 128'd1);
            chk("hold_data",  bus.out_data, p_dat);
         end else if (p_vld && p_rdy && !bus.out_valid) begin
            chk("retain_data", bus.out_data, p_dat);
         end
         if (bus.out_valid && bus.out_ready && !rst) begin
            if (exp_q.size() == 0) begin
               chk("xfer_unexpected", bus.out_data, 128'd0);
               if (bus.out_data == 128'd0) begin
                  bad++;
                  $display("FAIL xfer_unexpected actual=transfer required=none");
               end
            end else begin
               e = exp_q.pop_front();
               chk("block_data", bus.out_data, e);
               delivered++;
            end
         end
         p_vld = bus.out_valid;
         p_rdy = bus.out_ready;
         p_rst = rst;
         p_dat = bus.out_data;
      end
   end

   // stimulus
   initial begin
      logic       a;
      logic       v, c, ordy;
      logic [7:0] d;
      int         target;
      part = '0;
      // reset for a few cycles
      for (int i = 0; i < 3; i++) step(1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, a);

      // back-to-back 0x00..0x0F with the core always ready
      for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
      idle(1'b1, 2);

      // full block held off for 5 cycles while the host keeps offering a byte
      for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, a);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a);
      idle(1'b0, 2);

      // clear drops partial block and the byte offered alongside it
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      send(8'hCC, 1'b1);
      step(1'b1, 8'hDD, 1'b1, 1'b1, 1'b0, a);
      for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b1);
      idle(1'b1, 2);

      // reset mid-block, then a clean block
      for (int i = 0; i < 7; i++) send(8'(8'h60 + i), 1'b1);
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, a);
      for (int i = 0; i < 16; i++) send(8'(8'h80 + i), 1'b1);
      idle(1'b1, 2);

      // reset while a block is held
      for (int i = 0; i < 16; i++) send(8'(8'hC0 + i), 1'b0);
      idle(1'b0, 1);
      step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, a);
      idle(1'b1, 2);

      // random traffic and backpressure for 100 blocks
      target = made + 100;
      d = 8'($urandom);
      for (int cyc = 0; cyc < 30000 && made < target; cyc++) begin
         v    = ($urandom % 4) != 0;
         ordy = ($urandom % 3) != 0;
         c    = ($urandom % 64) == 0;
         step(v, d, c, ordy, 1'b0, a);
         if (a) d = 8'($urandom);
      end
      if (made < target) chk("random_timeout", 128'(made), 128'(target));

      // drain
      for (int i = 0; i < 200 && pending > 0; i++) idle(1'b1, 1);
      idle(1'b1, 2);
      chk("drain_empty", 128'(exp_q.size()), 128'd0);
      chk("delivered",   128'(delivered), 128'(made - flushed));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/in_block_assembler.md
IN_BLOCK_ASSEMBLER -- requirements
Module: in_block_assembler

Interface
REQ-001 Parameters: none; widths fixed to 8-bit byte lane, 128-bit AES block.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  8  plaintext/key byte from host side.
REQ-005 in_valid  input  1  in_data valid this cycle.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 clear  input  1  discard partially assembled block.
REQ-008 out_data  output  128  assembled block to AES core, registered.
REQ-009 out_valid  output  1  out_data holds a complete block.
REQ-010 out_ready  input  1  AES core consumes out_data this cycle.
REQ-011 byte_cnt  output  4  bytes held in assembly buffer (0..15), registered.

Function
REQ-012 Byte accepted iff in_valid && in_ready on a rising edge; no other condition stores a byte.
REQ-013 k-th accepted byte of a block (k=0..15) SHALL land in bits [8k+7:8k]; byte 0 in LSBs, same lane order as the AES output register.
REQ-014 byte_cnt increments by 1 per accepted byte, wraps 15->0 on 16th byte.
REQ-015 On 16th byte accept, out_data loads {in_data, 15 buffered bytes} in that same edge; out_valid high from next cycle (latency 1 cycle from last byte).
REQ-016 Output handshake: transfer iff out_valid && out_ready; out_data and out_valid SHALL remain stable while out_valid && !out_ready.
REQ-017 After transfer with no new block loaded, out_valid low next cycle; out_data retains last value.
REQ-018 16th byte accepted in same cycle as output transfer: out_data reloads with new block, out_valid stays high, no bubble.
REQ-019 States (non-double-buffered): FILL (out_valid=0, in_ready=1), HOLD (out_valid=1, in_ready=0); FILL->HOLD on 16th byte; HOLD->FILL on transfer.
REQ-020 in_ready SHALL be decoded from registered state only; no combinational path from in_valid or out_ready to in_ready.
REQ-021 clear high: byte_cnt->0 next cycle, partial bytes discarded; clear has priority over a byte presented same cycle (byte dropped even if in_ready=1).
REQ-022 clear SHALL NOT affect out_data/out_valid; a held complete block survives clear.
REQ-023 in_valid while in_ready=0: byte not stored, byte_cnt unchanged; sender must hold.

Reset
REQ-024 rst high: state FILL, byte_cnt=0, out_valid=0, out_data=0, assembly buffer=0, in_ready=0 while rst high.
REQ-025 in_ready=1 first cycle after rst deasserts; rst mid-block or during HOLD discards all data, no transfer completes that cycle.
REQ-026 rst has priority over clear, in_valid, out_ready.

Configuration
REQ-027 Macro IN_ASM_DOUBLE_BUF_EN defined: assembly buffer independent of out_data; states FILL (out empty), FILL_HOLD (out full, assembling), STALL (out full, assembly has 16 bytes, in_ready=0).
REQ-028 With IN_ASM_DOUBLE_BUF_EN: in_ready=1 in FILL and FILL_HOLD; in STALL, transfer moves assembly buffer to out_data, out_valid stays high, ->FILL_HOLD, byte_cnt=0; STALL entered when 16th byte accepted in FILL_HOLD without same-cycle transfer.
REQ-029 Without IN_ASM_DOUBLE_BUF_EN: behaviour per REQ-019, single block in flight, in_ready=0 throughout HOLD.

Verification
REQ-030 Reset, then bytes 0x00..0x0F back-to-back, out_ready=1 -> out_valid high 1 cycle after byte 0x0F, out_data=0x0F0E0D0C0B0A09080706050403020100, byte_cnt=0.
REQ-031 Full block with out_ready=0 for 5 cycles -> out_data/out_valid stable 5 cycles; in_ready=0 (non-DB); transfer on cycle 6, out_valid low cycle 7.
REQ-032 Send 0xAA,0xBB,0xCC; clear with in_valid=1,in_data=0xDD same cycle; then 16 bytes 0x10..0x1F -> out_data=0x1F1E...1110, no 0xAA/0xDD present.
REQ-033 rst after 7 bytes -> byte_cnt=0, out_valid=0; next 16 bytes form a clean block.
REQ-034 DB build: block A held with out_ready=0, stream 16 bytes of block B -> STALL, in_ready=0; out_ready=1 -> A transfers, out_data=B next cycle, out_valid stays high.
REQ-035 Random in_valid/out_ready backpressure, 100 blocks -> every block delivered once, in order, lane order per REQ-013.
